// File: rtl/magma_stream_pkg.sv
// Shared stream types for the magma stream slices.
// The state encoding is visible on the slice debug port, so its order is fixed.
package magma_stream_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } slice_state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous active-high clear.
// The count sticks at all-ones and only RESET brings it back to zero.
module sat_counter #(
    parameter int CNT_WIDTH = 8
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic                 inc,
    output logic [CNT_WIDTH-1:0] count
);

    logic [CNT_WIDTH-1:0] count_q;
    logic [CNT_WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc && (count_q != {CNT_WIDTH{1'b1}})) begin
            count_d = count_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/skid_reg_slice.sv
// Registered ready/valid slice with a one-entry skid buffer and a stall counter.
// I_ready comes straight from a flop, so the downstream ready path stops here.
module skid_reg_slice
    import magma_stream_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int CNT_WIDTH = 8
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic [WIDTH-1:0]     I_data,
    input  logic                 I_valid,
    output logic                 I_ready,
    output logic [WIDTH-1:0]     O_data,
    output logic                 O_valid,
    input  logic                 O_ready,
    output logic [CNT_WIDTH-1:0] stall_count,
    output logic [1:0]           state_o
);

    // Handshake: a beat moves on a port at a posedge where its valid and ready
    // are both high; a producer holding valid may not be back-pressured away.
    slice_state_t     state_q;
    slice_state_t     state_d;
    logic [WIDTH-1:0] o_data_q;
    logic [WIDTH-1:0] o_data_d;
    logic [WIDTH-1:0] skid_q;
    logic [WIDTH-1:0] skid_d;
    logic             i_ready_q;
    logic             i_ready_d;
    logic             o_valid;
    logic             in_xfer;
    logic             out_xfer;

    assign o_valid  = (state_q != EMPTY);
    assign in_xfer  = I_valid && i_ready_q;
    assign out_xfer = o_valid && O_ready;

    always_comb begin
        state_d  = state_q;
        o_data_d = o_data_q;
        skid_d   = skid_q;
        case (state_q)
            EMPTY: begin
                if (in_xfer) begin
                    state_d  = ONE;
                    o_data_d = I_data;
                end
            end
            ONE: begin
                if (in_xfer && !out_xfer) begin
                    state_d = FULL;
                    skid_d  = I_data;
                end else if (in_xfer && out_xfer) begin
                    o_data_d = I_data;
                end else if (out_xfer) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                // I_ready is low here, so only the drain side can move.
                if (out_xfer) begin
                    state_d  = ONE;
                    o_data_d = skid_q;
                end
            end
            default: begin
                state_d = EMPTY;
            end
        endcase
        i_ready_d = (state_d != FULL);
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q   <= EMPTY;
            o_data_q  <= '0;
            skid_q    <= '0;
            i_ready_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            o_data_q  <= o_data_d;
            skid_q    <= skid_d;
            i_ready_q <= i_ready_d;
        end
    end

    sat_counter #(
        .CNT_WIDTH (CNT_WIDTH)
    ) u_stall_cnt (
        .CLK   (CLK),
        .RESET (RESET),
        .inc   (o_valid && !O_ready),
        .count (stall_count)
    );

    assign I_ready = i_ready_q;
    assign O_data  = o_data_q;
    assign O_valid = o_valid;
    assign state_o = state_q;

    property p_hold_while_stalled;
        @(posedge CLK) disable iff (RESET)
            (O_valid && !O_ready) |-> ##1 (O_valid && $stable(O_data));
    endproperty
    a_hold_while_stalled: assert property (p_hold_while_stalled);

    property p_accept_gives_valid;
        @(posedge CLK) disable iff (RESET)
            (I_valid && I_ready) |-> ##1 O_valid;
    endproperty
    a_accept_gives_valid: assert property (p_accept_gives_valid);

    property p_no_ready_when_full;
        @(posedge CLK) disable iff (RESET)
            !((state_q == FULL) && I_ready);
    endproperty
    a_no_ready_when_full: assert property (p_no_ready_when_full);

endmodule

// File: tb/tb_skid_reg_slice.sv
// Bench for skid_reg_slice: a queue model checks every cycle, scenario tasks add
// targeted checks; a second instance with a 4-bit counter covers saturation.
module tb_skid_reg_slice;

  logic       CLK;
  logic       RESET;
  logic [7:0] I_data;
  logic       I_valid;
  logic       I_ready;
  logic [7:0] O_data;
  logic       O_valid;
  logic       O_ready;
  logic [7:0] stall_count;
  logic [1:0] state_o;

  logic       s_reset;
  logic [7:0] s_i_data;
  logic       s_i_valid;
  logic       s_i_ready;
  logic [7:0] s_o_data;
  logic       s_o_valid;
  logic       s_o_ready;
  logic [3:0] s_stall;
  logic [1:0] s_state;

  int vectors = 0;
  int miscompares = 0;

  // clock / reset
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  skid_reg_slice #(.WIDTH(8), .CNT_WIDTH(8)) dut (
    .CLK         (CLK),
    .RESET       (RESET),
    .I_data      (I_data),
    .I_valid     (I_valid),
    .I_ready     (I_ready),
    .O_data      (O_data),
    .O_valid     (O_valid),
    .O_ready     (O_ready),
    .stall_count (stall_count),
    .state_o     (state_o)
  );

  skid_reg_slice #(.WIDTH(8), .CNT_WIDTH(4)) dut_sat (
    .CLK         (CLK),
    .RESET       (s_reset),
    .I_data      (s_i_data),
    .I_valid     (s_i_valid),
    .I_ready     (s_i_ready),
    .O_data      (s_o_data),
    .O_valid     (s_o_valid),
    .O_ready     (s_o_ready),
    .stall_count (s_stall),
    .state_o     (s_state)
  );

  // scoreboard: reference FIFO of depth 2 plus ready, hold-data and stall models
  logic [7:0] exp_q[$];
  logic       model_ok = 1'b0;
  logic       rdy_exp = 1'b0;
  logic [7:0] hold_data = 8'h00;
  logic [7:0] stall_exp = 8'h00;
  logic [7:0] exp_data;
  logic       m_in;
  logic       m_out;
  int         pops = 0;

  always @(negedge CLK) begin
    if (model_ok) begin
      exp_data = (exp_q.size() != 0) ? exp_q[0] : hold_data;
      vectors++;
      if (I_ready !== rdy_exp) begin
        miscompares++;
        $display("FAIL sb_i_ready t=%0t got %b exp %b", $time, I_ready, rdy_exp);
      end
      vectors++;
      if (O_valid !== (exp_q.size() != 0)) begin
        miscompares++;
        $display("FAIL sb_o_valid t=%0t got %b exp %b", $time, O_valid, exp_q.size() != 0);
      end
      vectors++;
      if (O_data !== exp_data) begin
        miscompares++;
        $display("FAIL sb_o_data t=%0t got %h exp %h", $time, O_data, exp_data);
      end
      vectors++;
      if (stall_count !== stall_exp) begin
        miscompares++;
        $display("FAIL sb_stall t=%0t got %0d exp %0d", $time, stall_count, stall_exp);
      end
      vectors++;
      if (state_o !== 2'(exp_q.size())) begin
        miscompares++;
        $display("FAIL sb_state t=%0t got %0d exp %0d", $time, state_o, exp_q.size());
      end
      hold_data = exp_data;
    end
    if (RESET) begin
      exp_q.delete();
      rdy_exp   = 1'b0;
      hold_data = 8'h00;
      stall_exp = 8'h00;
      model_ok  = 1'b1;
    end else if (model_ok) begin
      m_in  = I_valid && rdy_exp;
      m_out = (exp_q.size() != 0) && O_ready;
      if ((exp_q.size() != 0) && !O_ready && (stall_exp != 8'hFF)) stall_exp = stall_exp + 8'd1;
      if (m_out) begin
        void'(exp_q.pop_front());
        pops++;
      end
      if (m_in) exp_q.push_back(I_data);
      rdy_exp = (exp_q.size() < 2);
    end
  end

  initial begin
    #1000000;
    miscompares++;
    $display("FAIL watchdog t=%0t", $time);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $fatal(1, "watchdog expired");
  end

  // driver tasks: each starts and ends 1 time unit after a posedge
  task automatic test_reset();
    RESET = 1'b1; I_valid = 1'b1; I_data = 8'hAA; O_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      vectors++;
      if (O_valid !== 1'b0) begin miscompares++; $display("FAIL rst_o_valid got %b exp 0", O_valid); end
      vectors++;
      if (O_data !== 8'h00) begin miscompares++; $display("FAIL rst_o_data got %h exp 00", O_data); end
      vectors++;
      if (I_ready !== 1'b0) begin miscompares++; $display("FAIL rst_i_ready got %b exp 0", I_ready); end
      vectors++;
      if (stall_count !== 8'h00) begin miscompares++; $display("FAIL rst_stall got %0d exp 0", stall_count); end
    end
    @(posedge CLK); #1;
    RESET = 1'b0; I_valid = 1'b0;
    @(negedge CLK);
    vectors++;
    if (I_ready !== 1'b0) begin miscompares++; $display("FAIL rst_ready_early got %b exp 0", I_ready); end
    @(posedge CLK); #1;
    @(negedge CLK);
    vectors++;
    if (I_ready !== 1'b1) begin miscompares++; $display("FAIL rst_ready_rise got %b exp 1", I_ready); end
    @(posedge CLK); #1;
  endtask

  task automatic test_streaming();
    int p0;
    int n;
    p0 = pops;
    O_ready = 1'b1;
    for (int v = 1; v <= 16; v++) begin
      I_valid = 1'b1; I_data = 8'(v);
      @(negedge CLK);
      vectors++;
      if (I_ready !== 1'b1) begin miscompares++; $display("FAIL stream_ready beat %0d got %b exp 1", v, I_ready); end
      if (v > 1) begin
        vectors++;
        if (O_valid !== 1'b1 || O_data !== 8'(v - 1)) begin
          miscompares++;
          $display("FAIL stream_data beat %0d got %b/%h exp 1/%h", v, O_valid, O_data, 8'(v - 1));
        end
      end
      @(posedge CLK); #1;
    end
    I_valid = 1'b0;
    @(negedge CLK);
    vectors++;
    if (O_valid !== 1'b1 || O_data !== 8'h10) begin miscompares++; $display("FAIL stream_last got %b/%h exp 1/10", O_valid, O_data); end
    vectors++;
    if (stall_count !== 8'h00) begin miscompares++; $display("FAIL stream_stall got %0d exp 0", stall_count); end
    @(posedge CLK); #1;
    n = 0;
    while (exp_q.size() != 0 && n < 8) begin @(posedge CLK); #1; n++; end
    vectors++;
    if (exp_q.size() != 0) begin miscompares++; $display("FAIL stream_drain got %0d left exp 0", exp_q.size()); end
    vectors++;
    if (pops - p0 != 16) begin miscompares++; $display("FAIL stream_count got %0d exp 16", pops - p0); end
  endtask

  task automatic test_skid();
    O_ready = 1'b1; I_valid = 1'b1; I_data = 8'h11;
    @(posedge CLK); #1;
    I_data = 8'h22; O_ready = 1'b0;
    @(posedge CLK); #1;
    I_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      vectors++;
      if (I_ready !== 1'b0) begin miscompares++; $display("FAIL skid_ready got %b exp 0", I_ready); end
      vectors++;
      if (O_valid !== 1'b1 || O_data !== 8'h11) begin miscompares++; $display("FAIL skid_hold got %b/%h exp 1/11", O_valid, O_data); end
      vectors++;
      if (state_o !== 2'd2) begin miscompares++; $display("FAIL skid_full got %0d exp 2", state_o); end
      @(posedge CLK); #1;
    end
    O_ready = 1'b1;
    @(negedge CLK);
    vectors++;
    if (O_data !== 8'h11) begin miscompares++; $display("FAIL skid_first got %h exp 11", O_data); end
    @(posedge CLK); #1;
    @(negedge CLK);
    vectors++;
    if (O_valid !== 1'b1 || O_data !== 8'h22) begin miscompares++; $display("FAIL skid_second got %b/%h exp 1/22", O_valid, O_data); end
    @(posedge CLK); #1;
    @(negedge CLK);
    vectors++;
    if (O_valid !== 1'b0) begin miscompares++; $display("FAIL skid_empty got %b exp 0", O_valid); end
    @(posedge CLK); #1;
  endtask

  task automatic test_saturation();
    logic [3:0] want;
    s_o_ready = 1'b0; s_i_valid = 1'b0; s_i_data = 8'h00;
    @(posedge CLK); #1;
    s_reset = 1'b0;
    @(posedge CLK); #1;
    s_i_valid = 1'b1; s_i_data = 8'h5A;
    @(posedge CLK); #1;
    s_i_valid = 1'b0;
    for (int i = 0; i <= 20; i++) begin
      @(negedge CLK);
      want = (i < 15) ? 4'(i) : 4'd15;
      vectors++;
      if (s_stall !== want) begin miscompares++; $display("FAIL sat_count cycle %0d got %0d exp %0d", i, s_stall, want); end
      vectors++;
      if (s_o_valid !== 1'b1 || s_o_data !== 8'h5A) begin miscompares++; $display("FAIL sat_hold got %b/%h exp 1/5a", s_o_valid, s_o_data); end
      @(posedge CLK); #1;
    end
  endtask

  task automatic test_reset_mid();
    O_ready = 1'b1; I_valid = 1'b1; I_data = 8'h33;
    @(posedge CLK); #1;
    I_data = 8'h44; O_ready = 1'b0;
    @(posedge CLK); #1;
    I_valid = 1'b0;
    @(negedge CLK);
    vectors++;
    if (state_o !== 2'd2) begin miscompares++; $display("FAIL mid_full got %0d exp 2", state_o); end
    @(posedge CLK); #1;
    RESET = 1'b1;
    @(posedge CLK); #1;
    RESET = 1'b0;
    @(negedge CLK);
    vectors++;
    if (O_valid !== 1'b0) begin miscompares++; $display("FAIL mid_o_valid got %b exp 0", O_valid); end
    vectors++;
    if (I_ready !== 1'b0) begin miscompares++; $display("FAIL mid_i_ready got %b exp 0", I_ready); end
    @(posedge CLK); #1;
    O_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      I_valid = (i < 4);
      I_data  = 8'h50 + 8'(i);
      @(negedge CLK);
      vectors++;
      if (O_valid === 1'b1 && (O_data === 8'h33 || O_data === 8'h44)) begin
        miscompares++;
        $display("FAIL mid_stale got %h exp not 33/44", O_data);
      end
      @(posedge CLK); #1;
    end
    I_valid = 1'b0;
  endtask

  task automatic test_random();
    int p0;
    int n;
    p0 = pops;
    for (int c = 0; c < 10000; c++) begin
      I_valid = 1'($urandom_range(0, 1));
      I_data  = 8'($urandom_range(0, 255));
      O_ready = 1'($urandom_range(0, 1));
      @(posedge CLK); #1;
    end
    I_valid = 1'b0; O_ready = 1'b1;
    n = 0;
    while (exp_q.size() != 0 && n < 8) begin @(posedge CLK); #1; n++; end
    vectors++;
    if (exp_q.size() != 0) begin miscompares++; $display("FAIL rand_drain got %0d left exp 0", exp_q.size()); end
    vectors++;
    if (pops - p0 < 1000) begin miscompares++; $display("FAIL rand_throughput got %0d beats exp >= 1000", pops - p0); end
  endtask

  initial begin
    RESET = 1'b1; I_valid = 1'b0; I_data = 8'h00; O_ready = 1'b0;
    s_reset = 1'b1; s_i_valid = 1'b0; s_i_data = 8'h00; s_o_ready = 1'b0;
    test_reset();
    test_streaming();
    test_skid();
    test_saturation();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
